// File: rtl/cache_line_fill_unit.sv
// Cache line refill engine: accepts one fetch miss, issues a line read, gathers
// the beats MSB-first into a full line and pulses the CacheMemory update port once.
module cache_line_fill_unit #(
    parameter int TAG_W    = 51,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 5,
    parameter int LINE_W   = 256,
    parameter int BEAT_W   = 64
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                missValid_i,
    input  logic [TAG_W-1:0]    missTag_i,
    input  logic [INDEX_W-1:0]  missIndex_i,
    input  logic [OFFSET_W-1:0] missOffset_i,
    output logic                missReady_o,
    output logic                memReqValid_o,
    output logic [63:0]         memReqAddr_o,
    input  logic                memReqReady_i,
    input  logic                memRespValid_i,
    input  logic [BEAT_W-1:0]   memRespData_i,
    output logic                updateEnable_o,
    output logic [LINE_W-1:0]   newCacheline_o,
    output logic [TAG_W-1:0]    newTag_o,
    output logic [INDEX_W-1:0]  newIndex_o,
    output logic [OFFSET_W-1:0] newOffset_o,
    output logic                busy_o
);

    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ADDR_RW = TAG_W + INDEX_W + OFFSET_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RECV  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  index_q;
    logic [OFFSET_W-1:0] offset_q;
    logic [BEAT_W-1:0]   beat_q [BEATS];
    logic                capture;
    logic                beat_store;
    logic [ADDR_RW-1:0]  addr_raw;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        beat_store = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (missValid_i) begin
                    capture = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (memReqReady_i) begin
                    cnt_d   = '0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                // Gaps in the response stream simply hold here without counting.
                if (memRespValid_i) begin
                    beat_store = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tag_q    <= '0;
            index_q  <= '0;
            offset_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                tag_q    <= missTag_i;
                index_q  <= missIndex_i;
                offset_q <= missOffset_i;
            end
        end
    end

    // Beat k lands in the k-th slice counted from the MSB end of the line.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                beat_q[gi] <= '0;
            end else if (capture) begin
                beat_q[gi] <= '0;
            end else if (beat_store && (cnt_q == CNT_W'(gi))) begin
                beat_q[gi] <= memRespData_i;
            end
        end
        assign newCacheline_o[LINE_W-1-gi*BEAT_W -: BEAT_W] = beat_q[gi];
    end

    assign addr_raw       = {tag_q, index_q, {OFFSET_W{1'b0}}};
    assign memReqAddr_o   = 64'(addr_raw);
    assign missReady_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign memReqValid_o  = (state_q == S_REQ);
    assign updateEnable_o = (state_q == S_WRITE);
    assign newTag_o       = tag_q;
    assign newIndex_o     = index_q;
    assign newOffset_o    = offset_q;

endmodule
